spell_mem_bus: RTL and testbench

- Data-memory bus controller between the spell core's load/store unit and the memory-mapped targets. It sits directly upstream of the IO port peripheral.
- Latches one CPU request and decodes its address into the IO window or the data-RAM window.
- Issues a single-cycle select strobe to the chosen target, then waits for that target's data_ready.
- Returns read data to the core with a one-cycle ready pulse; an optional timeout terminates hung accesses.

---
 rtl/spell_mem_bus_if.sv | 42 ++++
 rtl/spell_mem_bus.sv | 142 ++++++++++++++
 tb/tb_spell_mem_bus.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spell_mem_bus_if.sv
// rtl/spell_mem_bus_if.sv - core/IO/RAM signal bundle for the spell data-memory bus controller
interface spell_mem_bus_if;
    logic       cpu_req;
    logic [7:0] cpu_addr;
    logic       cpu_write;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_ready;
    logic       cpu_error;

    logic       io_select;
    logic [7:0] io_addr;
    logic [7:0] io_data_in;
    logic       io_write;
    logic [7:0] io_data_out;
    logic       io_data_ready;

    logic       ram_select;
    logic [7:0] ram_addr;
    logic [7:0] ram_data_in;
    logic       ram_write;
    logic [7:0] ram_data_out;
    logic       ram_data_ready;

    modport slave (
        input  cpu_req, cpu_addr, cpu_write, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_error,
        output io_select, io_addr, io_data_in, io_write,
        input  io_data_out, io_data_ready,
        output ram_select, ram_addr, ram_data_in, ram_write,
        input  ram_data_out, ram_data_ready
    );

    modport master (
        output cpu_req, cpu_addr, cpu_write, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_error,
        input  io_select, io_addr, io_data_in, io_write,
        output io_data_out, io_data_ready,
        input  ram_select, ram_addr, ram_data_in, ram_write,
        output ram_data_out, ram_data_ready
    );
endinterface

// File: rtl/spell_mem_bus.sv
// rtl/spell_mem_bus.sv - data-memory bus controller routing core accesses to the IO window or data RAM
// Optional hung-access timeout enabled by defining SPELL_MEM_BUS_TIMEOUT_EN.
module spell_mem_bus #(
`ifdef SPELL_MEM_BUS_TIMEOUT_EN
    parameter int         TIMEOUT_CYCLES = 16,
`endif
    parameter logic [7:0] IO_FIRST = 8'h20,
    parameter logic [7:0] IO_LAST  = 8'h5F
) (
    input  logic          clock,
    input  logic          reset_n,
    spell_mem_bus_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IO  = 2'd1,
        WAIT_RAM = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       write_q, write_d;
    logic       io_sel_q, io_sel_d;
    logic       ram_sel_q, ram_sel_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ready_q, ready_d;
`ifdef SPELL_MEM_BUS_TIMEOUT_EN
    logic       error_q, error_d;
    logic [7:0] cnt_q, cnt_d;
`endif

    logic in_io_window;
    assign in_io_window = (bus.cpu_addr >= IO_FIRST) && (bus.cpu_addr <= IO_LAST);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        // Selects default low so every strobe lasts exactly one cycle.
        io_sel_d  = 1'b0;
        ram_sel_d = 1'b0;
        ready_d   = 1'b0;
`ifdef SPELL_MEM_BUS_TIMEOUT_EN
        error_d   = 1'b0;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    write_d = bus.cpu_write;
`ifdef SPELL_MEM_BUS_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                    if (in_io_window) begin
                        io_sel_d = 1'b1;
                        state_d  = WAIT_IO;
                    end else begin
                        ram_sel_d = 1'b1;
                        state_d   = WAIT_RAM;
                    end
                end
            end
            WAIT_IO, WAIT_RAM: begin
                if ((state_q == WAIT_IO) ? bus.io_data_ready : bus.ram_data_ready) begin
                    rdata_d = (state_q == WAIT_IO) ? bus.io_data_out : bus.ram_data_out;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
`ifdef SPELL_MEM_BUS_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = 8'hFF;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= 8'd0;
            wdata_q   <= 8'd0;
            write_q   <= 1'b0;
            io_sel_q  <= 1'b0;
            ram_sel_q <= 1'b0;
            rdata_q   <= 8'd0;
            ready_q   <= 1'b0;
`ifdef SPELL_MEM_BUS_TIMEOUT_EN
            error_q   <= 1'b0;
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            io_sel_q  <= io_sel_d;
            ram_sel_q <= ram_sel_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
`ifdef SPELL_MEM_BUS_TIMEOUT_EN
            error_q   <= error_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.cpu_rdata   = rdata_q;
    assign bus.cpu_ready   = ready_q;
`ifdef SPELL_MEM_BUS_TIMEOUT_EN
    assign bus.cpu_error   = error_q;
`else
    assign bus.cpu_error   = 1'b0;
`endif
    assign bus.io_select   = io_sel_q;
    assign bus.io_addr     = addr_q;
    assign bus.io_data_in  = wdata_q;
    assign bus.io_write    = write_q;
    assign bus.ram_select  = ram_sel_q;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_data_in = wdata_q;
    assign bus.ram_write   = write_q;

endmodule

// File: tb/tb_spell_mem_bus.sv
// tb/tb_spell_mem_bus.sv - directed-vector bench for spell_mem_bus
module tb_spell_mem_bus;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    spell_mem_bus_if bus ();

    spell_mem_bus dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {28'd0, bus.io_select, bus.ram_select, bus.cpu_ready, bus.cpu_error}, 32'd0);
        chk({tag, "_wr"}, {30'd0, bus.io_write, bus.ram_write}, 32'd0);
        chk({tag, "_addr"}, {16'd0, bus.io_addr, bus.ram_addr}, 32'd0);
        chk({tag, "_data"}, {8'd0, bus.io_data_in, bus.ram_data_in, bus.cpu_rdata}, 32'd0);
    endtask

    // One access: target raises data_ready in cycle lat+1 after acceptance.
    // noise drives the other target's data_ready while waiting; keep leaves cpu_req high.
    task automatic txn(input string tag, input logic [7:0] a, input logic w, input logic [7:0] wd,
                       input logic [7:0] rd, input int lat, input bit to_io,
                       input bit noise, input bit keep);
        @(negedge clock);
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_write = w;
        bus.cpu_wdata = wd;
        @(posedge clock); #1;
        chk({tag, "_io_sel"}, bus.io_select, to_io);
        chk({tag, "_ram_sel"}, bus.ram_select, !to_io);
        chk({tag, "_addr"}, to_io ? bus.io_addr : bus.ram_addr, a);
        chk({tag, "_wdata"}, to_io ? bus.io_data_in : bus.ram_data_in, wd);
        chk({tag, "_write"}, to_io ? bus.io_write : bus.ram_write, w);
        chk({tag, "_rdy_acc"}, bus.cpu_ready, 1'b0);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clock);
            if (to_io) begin
                bus.io_data_ready  = (k == lat + 1);
                bus.io_data_out    = rd;
                bus.ram_data_ready = noise && (k <= lat);
                bus.ram_data_out   = 8'hEE;
            end else begin
                bus.ram_data_ready = (k == lat + 1);
                bus.ram_data_out   = rd;
                bus.io_data_ready  = noise && (k <= lat);
                bus.io_data_out    = 8'hEE;
            end
            @(posedge clock); #1;
            chk({tag, "_sel_wait"}, {bus.io_select, bus.ram_select}, 2'b00);
            chk({tag, "_rdy"}, bus.cpu_ready, (k == lat + 1));
        end
        chk({tag, "_rdata"}, bus.cpu_rdata, rd);
        chk({tag, "_err"}, bus.cpu_error, 1'b0);
        @(negedge clock);
        bus.io_data_ready  = 1'b0;
        bus.ram_data_ready = 1'b0;
        if (!keep) bus.cpu_req = 1'b0;
        @(posedge clock); #1;
        chk({tag, "_rdy_done"}, bus.cpu_ready, 1'b0);
        chk({tag, "_sel_done"}, {bus.io_select, bus.ram_select}, 2'b00);
        chk({tag, "_rdata_hold"}, bus.cpu_rdata, rd);
    endtask

    initial begin
        int pulses;
        bus.cpu_req        = 1'b0;
        bus.cpu_addr       = 8'd0;
        bus.cpu_write      = 1'b0;
        bus.cpu_wdata      = 8'd0;
        bus.io_data_out    = 8'd0;
        bus.io_data_ready  = 1'b0;
        bus.ram_data_out   = 8'd0;
        bus.ram_data_ready = 1'b0;

        repeat (2) @(posedge clock);
        #1 chk_all_zero("reset");
        @(negedge clock) reset_n = 1'b1;

        txn("io_wr", 8'h38, 1'b1, 8'hA5, 8'h00, 1, 1'b1, 1'b0, 1'b0);
        txn("io_rd", 8'h36, 1'b0, 8'h00, 8'h5C, 1, 1'b1, 1'b1, 1'b0);

        // Reset while the controller waits on the RAM.
        @(negedge clock);
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h80; bus.cpu_write = 1'b1; bus.cpu_wdata = 8'h3C;
        @(posedge clock); #1;
        chk("rst_mid_sel", bus.ram_select, 1'b1);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        @(negedge clock);
        bus.cpu_req = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        chk("rst_no_rdy", bus.cpu_ready, 1'b0);
        txn("rst_io", 8'h40, 1'b0, 8'h00, 8'h91, 1, 1'b1, 1'b0, 1'b0);

        txn("dec_1f", 8'h1F, 1'b0, 8'h00, 8'h11, 3, 1'b0, 1'b0, 1'b0);
        txn("dec_20", 8'h20, 1'b0, 8'h00, 8'h22, 1, 1'b1, 1'b0, 1'b0);
        txn("dec_5f", 8'h5F, 1'b1, 8'h77, 8'h33, 1, 1'b1, 1'b0, 1'b0);
        txn("dec_60", 8'h60, 1'b0, 8'h00, 8'h44, 3, 1'b0, 1'b1, 1'b0);

        // cpu_req held across two transactions; DONE must not accept.
        txn("b2b_1", 8'h90, 1'b1, 8'h5A, 8'h66, 1, 1'b0, 1'b0, 1'b1);
        txn("b2b_2", 8'h25, 1'b0, 8'h00, 8'h99, 1, 1'b1, 1'b0, 1'b0);

`ifdef SPELL_MEM_BUS_TIMEOUT_EN
        @(negedge clock);
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'hC0; bus.cpu_write = 1'b0;
        @(posedge clock);
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clock); #1;
            if (bus.cpu_ready && k != 16) pulses++;
        end
        chk("to_early", pulses, 0);
        chk("to_rdy", bus.cpu_ready, 1'b1);
        chk("to_err", bus.cpu_error, 1'b1);
        chk("to_rdata", bus.cpu_rdata, 8'hFF);
        @(negedge clock);
        bus.cpu_req = 1'b0;
        bus.ram_data_ready = 1'b1;
        bus.ram_data_out = 8'h12;
        repeat (3) begin
            @(posedge clock); #1;
            chk("to_late_rdy", {bus.cpu_ready, bus.cpu_error}, 2'b00);
            chk("to_late_rdata", bus.cpu_rdata, 8'hFF);
        end
        @(negedge clock) bus.ram_data_ready = 1'b0;
`else
        @(negedge clock);
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'hC0; bus.cpu_write = 1'b0;
        pulses = 0;
        repeat (100) begin
            @(posedge clock); #1;
            if (bus.cpu_ready || bus.cpu_error) pulses++;
        end
        chk("no_timeout", pulses, 0);
        @(negedge clock);
        bus.cpu_req = 1'b0;
        reset_n = 1'b0;
        @(negedge clock) reset_n = 1'b1;
`endif
        txn("final", 8'hA0, 1'b0, 8'h00, 8'hC3, 2, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
